// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one registered-read sprite ROM among N_REQ draw engines.
// Each grant streams BURST_LEN consecutive addresses; pixels come back tagged to the owner.
module sprite_rom_arbiter #(
   parameter int N_REQ     = 4,
   parameter int ADDR_W    = 19,
   parameter int DATA_W    = 24,
   parameter int BURST_LEN = 32
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   output logic [N_REQ-1:0]        grant,
   output logic                    busy,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [DATA_W-1:0]       rom_data,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic                    rsp_last,
   output logic [DATA_W-1:0]       rsp_data
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(BURST_LEN);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_REQ - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [PTR_W-1:0]    rr_ptr_r;
   logic [PTR_W-1:0]    owner_r;
   logic [CNT_W-1:0]    cnt_r;
   logic [ADDR_W-1:0]   rom_addr_r;
   logic [N_REQ-1:0]    rsp_valid_r;
   logic                rsp_last_r;
   logic [PTR_W-1:0]    win_s;
   logic [PTR_W-1:0]    idx_s;
   logic                found_s;
   logic [N_REQ-1:0]    grant_s;
   int                  idx_v;

   function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
      logic [N_REQ-1:0] r;
      r      = '0;
      r[idx] = 1'b1;
      return r;
   endfunction

   // Winner search: first active request starting at rr_ptr and wrapping modulo N_REQ.
   always_comb begin
      win_s   = '0;
      idx_s   = '0;
      idx_v   = 0;
      found_s = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         idx_v = int'(rr_ptr_r) + i;
         idx_v = (idx_v >= N_REQ) ? (idx_v - N_REQ) : idx_v;
         idx_s = PTR_W'(idx_v);
         if (!found_s && req[idx_s]) begin
            win_s   = idx_s;
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Next-state logic and the combinational accept strobe.
   always_comb begin
      state_nxt_s = state_r;
      grant_s     = '0;
      case (state_r)
         ST_IDLE: begin
            if (found_s) begin
               state_nxt_s = ST_BURST;
               grant_s     = onehot(win_s);
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_BURST: begin
            if (cnt_r == LAST_CNT) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_BURST;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Burst address generator; the address holds on the final beat rather than stepping past the row.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rr_ptr_r   <= '0;
         owner_r    <= '0;
         cnt_r      <= '0;
         rom_addr_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (found_s) begin
                  owner_r    <= win_s;
                  rom_addr_r <= req_addr[int'(win_s)*ADDR_W +: ADDR_W];
                  cnt_r      <= '0;
                  rr_ptr_r   <= (win_s == LAST_PTR) ? '0 : (win_s + PTR_W'(1));
               end
            end
            ST_BURST: begin
               if (cnt_r != LAST_CNT) begin
                  rom_addr_r <= rom_addr_r + ADDR_W'(1);
                  cnt_r      <= cnt_r + CNT_W'(1);
               end
            end
            default: begin
               cnt_r <= '0;
            end
         endcase
      end
   end

   // Response tag delayed one cycle to line up with the ROM's registered read data.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rsp_valid_r <= '0;
         rsp_last_r  <= 1'b0;
      end else begin
         rsp_valid_r <= (state_r == ST_BURST) ? onehot(owner_r) : '0;
         rsp_last_r  <= (state_r == ST_BURST) && (cnt_r == LAST_CNT);
      end
   end

   assign grant     = grant_s;
   assign busy      = (state_r == ST_BURST);
   assign rom_addr  = rom_addr_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_last  = rsp_last_r;
   assign rsp_data  = rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter with BURST_LEN=4 and a ROM model returning data = address.
module tb_sprite_rom_arbiter;

   localparam int N  = 4;
   localparam int AW = 19;
   localparam int DW = 24;
   localparam int BL = 4;

   typedef struct packed {
      logic [N-1:0]  v;
      logic [DW-1:0] d;
      logic          l;
   } exp_t;

   logic            Clk;
   logic            Reset;
   logic [N-1:0]    req;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    grant;
   logic            busy;
   logic [AW-1:0]   rom_addr;
   logic [DW-1:0]   rom_data;
   logic [N-1:0]    rsp_valid;
   logic            rsp_last;
   logic [DW-1:0]   rsp_data;

   exp_t sb[$];
   int   n_cmp;
   int   n_err;

   sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
      .Clk(Clk), .Reset(Reset), .req(req), .req_addr(req_addr), .grant(grant),
      .busy(busy), .rom_addr(rom_addr), .rom_data(rom_data), .rsp_valid(rsp_valid),
      .rsp_last(rsp_last), .rsp_data(rsp_data)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ROM model: registered read, pixel equals its address.
   always @(posedge Clk) rom_data <= {5'b0, rom_addr};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      req_addr[i*AW +: AW] = a;
   endtask

   // One accepted burst: check grant in IDLE, queue the expected beats, track the address walk.
   task automatic arb(input logic [N-1:0] rv, input int w, input logic [AW-1:0] base, input bit hold);
      logic [N-1:0]  oh;
      logic [AW-1:0] a;
      oh = 4'b0001 << w;
      @(negedge Clk);
      req = rv;
      #1;
      chk("grant", 32'(grant), 32'(oh));
      chk("busy_idle", 32'(busy), 32'd0);
      for (int k = 0; k < BL; k++) begin
         a = base + 19'(k);
         sb.push_back('{v: oh, d: {5'b0, a}, l: (k == BL - 1)});
      end
      for (int k = 0; k < BL; k++) begin
         @(negedge Clk);
         if (k == 0 && !hold) req[w] = 1'b0;
         #1;
         a = base + 19'(k);
         chk("rom_addr", 32'(rom_addr), 32'(a));
         chk("busy_burst", 32'(busy), 32'd1);
         chk("grant_burst", 32'(grant), 32'd0);
      end
   endtask

   // Monitor: every presented pixel is matched against the head of the scoreboard.
   always @(negedge Clk) begin
      exp_t e;
      if (!Reset) begin
         if (rsp_valid != 4'b0000) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_rsp: got valid %b expected none at %0t", rsp_valid, $time);
            end else begin
               e = sb.pop_front();
               chk("rsp_valid", 32'(rsp_valid), 32'(e.v));
               chk("rsp_data", 32'(rsp_data), 32'(e.d));
               chk("rsp_last", 32'(rsp_last), 32'(e.l));
            end
         end else begin
            chk("rsp_last_idle", 32'(rsp_last), 32'd0);
         end
      end
   end

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      Reset    = 1'b1;
      req      = '0;
      req_addr = '0;
      #1;
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      @(negedge Clk);
      Reset = 1'b0;

      // Round-robin with everything requesting.
      set_addr(0, 19'h01000);
      set_addr(1, 19'h02000);
      set_addr(2, 19'h03000);
      set_addr(3, 19'h04000);
      arb(4'b1111, 0, 19'h01000, 1'b1);
      arb(4'b1111, 1, 19'h02000, 1'b1);
      arb(4'b1111, 2, 19'h03000, 1'b1);
      arb(4'b1111, 3, 19'h04000, 1'b1);
      arb(4'b1111, 0, 19'h01000, 1'b1);

      // Single burst from requester 2.
      set_addr(2, 19'h00100);
      arb(4'b0100, 2, 19'h00100, 1'b0);

      // Priority rotation.
      arb(4'b0010, 1, 19'h02000, 1'b0);
      arb(4'b0011, 0, 19'h01000, 1'b0);
      arb(4'b0011, 1, 19'h02000, 1'b0);

      // Address wrap at the top of the ROM.
      set_addr(3, 19'h7FFFE);
      arb(4'b1000, 3, 19'h7FFFE, 1'b0);

      // Reset mid-burst: only the first two beats ever appear.
      set_addr(1, 19'h05000);
      @(negedge Clk);
      req = 4'b0010;
      #1;
      chk("mid_grant", 32'(grant), 32'b0010);
      sb.push_back('{v: 4'b0010, d: 24'h005000, l: 1'b0});
      sb.push_back('{v: 4'b0010, d: 24'h005001, l: 1'b0});
      @(negedge Clk);
      req = 4'b0000;
      #1;
      chk("mid_addr0", 32'(rom_addr), 32'h05000);
      @(negedge Clk);
      #1;
      chk("mid_addr1", 32'(rom_addr), 32'h05001);
      @(negedge Clk);
      #2;
      Reset = 1'b1;
      #1;
      chk("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_rsp_last", 32'(rsp_last), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_grant", 32'(grant), 32'd0);
      @(negedge Clk);
      Reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         #1;
         chk("post_rst_valid", 32'(rsp_valid), 32'd0);
         chk("post_rst_busy", 32'(busy), 32'd0);
      end

      // Pointer is back at 0, so 1 beats 3.
      set_addr(3, 19'h06000);
      arb(4'b1010, 1, 19'h05000, 1'b0);
      arb(4'b1000, 3, 19'h06000, 1'b0);

      repeat (3) @(negedge Clk);
      #1;
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one single-read-port sprite frame RAM (registered read, 1-cycle latency, 19-bit address, 24-bit RGB out) among N_REQ drawing engines, e.g. the score-digit, tank and bullet renderers.
- Each grant runs a fixed-length burst of consecutive addresses, one sprite row, and returns pixels tagged to the owning requester.
- Sits between the per-sprite draw engines and the shared ROM instance in the color-mapper path.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 19, ROM address width.
- DATA_W, 24, pixel width (RGB888).
- BURST_LEN, 32, reads per grant, i.e. one sprite row (2..256).

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  request per requester; held high until granted.
- req_addr  in  N_REQ*ADDR_W  burst base address per requester; slice i = [i*ADDR_W +: ADDR_W].
- grant  out  N_REQ  one-hot accept strobe, combinational.
- busy  out  1  high while a burst is in progress (state BURST).
- rom_addr  out  ADDR_W  address to the shared ROM; registered.
- rom_data  in  DATA_W  ROM data_Out, valid one cycle after rom_addr.
- rsp_valid  out  N_REQ  one-hot: the pixel on rsp_data belongs to requester i; registered.
- rsp_last  out  1  marks the final beat of a burst; registered.
- rsp_data  out  DATA_W  direct pass-through of rom_data.

Behaviour:
- Reset (async, asserted):
  - state = IDLE, rr_ptr = 0.
  - rom_addr = 0, owner = 0, beat count = 0.
  - rsp_valid = 0, rsp_last = 0, grant = 0, busy = 0.
  - Reset asserted mid-burst aborts the burst. The ROM's stale output is never flagged valid.
- States:
  - IDLE:
    - If req is nonzero, winner w = first set bit scanning rr_ptr, rr_ptr+1, … mod N_REQ.
    - grant[w] = 1 combinationally in IDLE only.
    - At the clock edge: owner <= w, rom_addr <= req_addr[w], cnt <= 0, rr_ptr <= (w+1) mod N_REQ, state <= BURST.
    - If req is zero: grant = 0 and nothing changes.
  - BURST:
    - grant = 0 and busy = 1.
    - Each edge: rom_addr <= rom_addr+1, cnt <= cnt+1.
    - When cnt == BURST_LEN-1: state <= IDLE, and rom_addr holds its value (no increment).
- Requester contract:
  - Requester i samples grant[i] and may deassert req or change req_addr at that same edge.
  - Changing req_addr while ungranted is legal; the value present at the accept edge is used.
  - Dropping req before it is granted is legal; no grant is issued for it.
- Timing (accept edge = t0):
  - During cycle t0+k (k = 0..BURST_LEN-1), rom_addr = base+k.
  - During cycle t0+k+1: rsp_valid = onehot(owner), rsp_data = pixel at base+k, rsp_last = (k == BURST_LEN-1).
  - Implemented as a 1-stage registered tag: issue-valid, owner and last, delayed one cycle.
- Throughput:
  - A burst occupies BURST_LEN cycles, followed by exactly one IDLE cycle before the next grant.
  - Maximum duty is BURST_LEN/(BURST_LEN+1).
- Address arithmetic: rom_addr increments modulo 2^ADDR_W; 7FFFF+1 wraps to 00000 with no error flag.
- Fairness: the most recent winner has lowest priority next time. With all requesters active, grants rotate 0,1,2,3,0,…
- req changes during BURST are ignored; arbitration happens only in IDLE.
- rsp_valid outside a burst's response window is 0. rsp_data is don't-care when rsp_valid = 0.

Test Plan:
- Reset: assert Reset mid-cycle with no clock edge -> all registered outputs 0 immediately; busy = 0, grant = 0.
- Single burst (BURST_LEN=4, ROM model returns data = address): req[2]=1, base 0x00100 -> grant = 0100 for one cycle.
  - rom_addr = 100,101,102,103 on consecutive cycles.
  - rsp_valid = 0100 with data 100..103 one cycle later; rsp_last only on beat 103.
- Round-robin: req = 1111 held continuously -> grant order 0,1,2,3,0. Each burst is separated by one idle cycle; rsp_valid one-hot matches the order.
- Priority rotation: after a grant to 1, req = 0011 -> next grant goes to 0; after that, req = 0011 -> grant goes to 1.
- Wrap: base 0x7FFFE, BURST_LEN=4 -> rom_addr = 7FFFE, 7FFFF, 00000, 00001, with rsp_last on the 00001 beat.
- Reset mid-burst: assert Reset at beat 2 of 4, then release with req = 0 -> rsp_valid stays 0 and state is IDLE. The next req to 3 is granted to 3 (rr_ptr back to 0, scan from 0).
